// File: rtl/rom_arbiter.sv
// Two-port arbiter for a single-port synchronous-read ROM; one grant per cycle, 1-cycle read return.
// Optional grant counters are enabled with ROM_ARBITER_PERF_EN.
module rom_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
`ifdef ROM_ARBITER_PERF_EN
    input  logic              i_cnt_clr,
    output logic [15:0]       o_gnt_cnt0,
    output logic [15:0]       o_gnt_cnt1,
`endif
    input  logic              i_req0,
    input  logic [ADDR_W-1:0] i_addr0,
    output logic              o_gnt0,
    output logic              o_rvalid0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr1,
    output logic              o_gnt1,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data
);

    logic              last;      // port served by the most recent grant
    logic              inflight;
    logic              tag;
    logic [ADDR_W-1:0] held_addr;

    always_comb begin
        o_gnt0 = i_req0 && (!i_req1 || (FIXED_PRIO != 0) || last);
        o_gnt1 = i_req1 && !o_gnt0;
        if (o_gnt0)
            o_rom_addr = i_addr0;
        else if (o_gnt1)
            o_rom_addr = i_addr1;
        else
            o_rom_addr = held_addr;  // keep the ROM address stable while idle
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last      <= 1'b1;
            inflight  <= 1'b0;
            tag       <= 1'b0;
            held_addr <= '0;
        end else begin
            inflight <= o_gnt0 || o_gnt1;
            if (o_gnt0 || o_gnt1) begin
                tag       <= o_gnt1;
                last      <= o_gnt1;
                held_addr <= o_rom_addr;
            end
        end
    end

    assign o_rvalid0 = inflight && !tag;
    assign o_rvalid1 = inflight && tag;
    assign o_rdata   = i_rom_data;

`ifdef ROM_ARBITER_PERF_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_gnt_cnt0 <= '0;
            o_gnt_cnt1 <= '0;
        end else if (i_cnt_clr) begin
            o_gnt_cnt0 <= '0;
            o_gnt_cnt1 <= '0;
        end else begin
            if (o_gnt0 && (o_gnt_cnt0 != '1))
                o_gnt_cnt0 <= o_gnt_cnt0 + 16'd1;
            if (o_gnt1 && (o_gnt_cnt1 != '1))
                o_gnt_cnt1 <= o_gnt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter: round-robin and fixed-priority instances share stimulus.
// Grant counters are checked when ROM_ARBITER_PERF_EN is defined.
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [9:0]  addr0, addr1;

    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata, rom_data;
    logic [9:0]  rom_addr;

    logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1;
    logic [15:0] f_rdata, f_rom_data;
    logic [9:0]  f_rom_addr;

`ifdef ROM_ARBITER_PERF_EN
    logic        cnt_clr;
    logic [15:0] cnt0, cnt1, f_cnt0, f_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM contents: 16'hC000 ^ addr, except a marker word at address 5
    function automatic logic [15:0] rom_word(input logic [9:0] a);
        return (a == 10'h005) ? 16'hA5A5 : (16'hC000 ^ {6'b0, a});
    endfunction

    always @(posedge clk) begin
        rom_data   <= rom_word(rom_addr);
        f_rom_data <= rom_word(f_rom_addr);
    end

    rom_arbiter #(.ADDR_W(10), .DATA_W(16), .FIXED_PRIO(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
`ifdef ROM_ARBITER_PERF_EN
        .i_cnt_clr(cnt_clr), .o_gnt_cnt0(cnt0), .o_gnt_cnt1(cnt1),
`endif
        .i_req0(req0), .i_addr0(addr0), .o_gnt0(gnt0), .o_rvalid0(rvalid0),
        .i_req1(req1), .i_addr1(addr1), .o_gnt1(gnt1), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .o_rom_addr(rom_addr), .i_rom_data(rom_data)
    );

    rom_arbiter #(.ADDR_W(10), .DATA_W(16), .FIXED_PRIO(1)) dut_fixed (
        .i_clk(clk), .i_rst_n(rst_n),
`ifdef ROM_ARBITER_PERF_EN
        .i_cnt_clr(cnt_clr), .o_gnt_cnt0(f_cnt0), .o_gnt_cnt1(f_cnt1),
`endif
        .i_req0(req0), .i_addr0(addr0), .o_gnt0(f_gnt0), .o_rvalid0(f_rvalid0),
        .i_req1(req1), .i_addr1(addr1), .o_gnt1(f_gnt1), .o_rvalid1(f_rvalid1),
        .o_rdata(f_rdata), .o_rom_addr(f_rom_addr), .i_rom_data(f_rom_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0;  addr1 = '0;
`ifdef ROM_ARBITER_PERF_EN
        cnt_clr = 1'b0;
`endif
        #2;
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_no_gnt", 32'({gnt0, gnt1}), 32'd0);
        tick();
        rst_n = 1'b1;

        // single port 0 read
        tick();
        req0 = 1'b1; addr0 = 10'h005;
        #1;
        check("p0_gnt0", 32'(gnt0), 32'd1);
        check("p0_gnt1", 32'(gnt1), 32'd0);
        check("p0_addr", 32'(rom_addr), 32'h005);
        tick();
        req0 = 1'b0;
        check("p0_rvalid0", 32'(rvalid0), 32'd1);
        check("p0_rvalid1", 32'(rvalid1), 32'd0);
        check("p0_rdata", 32'(rdata), 32'hA5A5);

        // round-robin contention after a fresh reset
        do_reset();
        tick();
        req0 = 1'b1; addr0 = 10'h001;
        req1 = 1'b1; addr1 = 10'h002;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_gnt0", 32'(gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_gnt1", 32'(gnt1), (i % 2 == 0) ? 32'd0 : 32'd1);
            check("rr_addr", 32'(rom_addr), (i % 2 == 0) ? 32'h001 : 32'h002);
            if (i < 3) begin
                check("fx_gnt0", 32'(f_gnt0), 32'd1);
                check("fx_gnt1", 32'(f_gnt1), 32'd0);
            end
            tick();
            check("rr_rvalid0", 32'(rvalid0), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_rvalid1", 32'(rvalid1), (i % 2 == 0) ? 32'd0 : 32'd1);
            check("rr_rdata", 32'(rdata), (i % 2 == 0) ? 32'hC001 : 32'hC002);
        end
        // fixed priority: port 1 wins once port 0 drops
        req0 = 1'b0;
        #1;
        check("fx_p1_gnt1", 32'(f_gnt1), 32'd1);
        check("fx_p1_gnt0", 32'(f_gnt0), 32'd0);
        tick();
        req1 = 1'b0;
        check("fx_p1_rvalid1", 32'(f_rvalid1), 32'd1);
        check("fx_p1_rdata", 32'(f_rdata), 32'hC002);

        // idle address hold after a port 1 grant to 3FF
        tick();
        req1 = 1'b1; addr1 = 10'h3FF;
        #1;
        check("idle_gnt1", 32'(gnt1), 32'd1);
        tick();
        req1 = 1'b0; addr1 = 10'h000;
        #1;
        check("idle_rvalid1", 32'(rvalid1), 32'd1);
        check("idle_rdata", 32'(rdata), 32'hC3FF);
        for (int i = 0; i < 3; i++) begin
            check("idle_addr", 32'(rom_addr), 32'h3FF);
            tick();
            check("idle_rvalids", 32'({rvalid0, rvalid1}), 32'd0);
        end

        // reset while a port 0 read is in flight
        req0 = 1'b1; addr0 = 10'h007;
        #1;
        check("rf_gnt0", 32'(gnt0), 32'd1);
        #2;
        rst_n = 1'b0;
        req0 = 1'b0;
        tick();
        check("rf_rvalid0_in_rst", 32'(rvalid0), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rf_rvalid0_after", 32'(rvalid0), 32'd0);
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'h007; addr1 = 10'h009;
        #1;
        check("rf_first_gnt0", 32'(gnt0), 32'd1);
        check("rf_first_gnt1", 32'(gnt1), 32'd0);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        check("rf_resp_rdata", 32'(rdata), 32'hC007);
        tick();

`ifdef ROM_ARBITER_PERF_EN
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("perf_cleared0", 32'(cnt0), 32'd0);
        req0 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        req0 = 1'b0; req1 = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        req1 = 1'b0;
        check("perf_cnt0", 32'(cnt0), 32'd5);
        check("perf_cnt1", 32'(cnt1), 32'd2);
        req0 = 1'b1; cnt_clr = 1'b1;
        tick();
        req0 = 1'b0; cnt_clr = 1'b0;
        check("perf_clr_cnt0", 32'(cnt0), 32'd0);
        check("perf_clr_cnt1", 32'(cnt1), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
